// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding, data widths and a width helper.
package mult_arb_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  typedef logic [1:0] state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier signals around the arbiter; slave is the arbiter's view,
// master is the view of the requesters and multiplier that surround it.
interface mult_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]                    req;
  logic [mult_arb_pkg::OP_W*NUM_REQ-1:0] a_flat;
  logic [mult_arb_pkg::OP_W*NUM_REQ-1:0] b_flat;
  logic [NUM_REQ-1:0]                    gnt;
  logic [NUM_REQ-1:0]                    rsp_valid;
  logic [mult_arb_pkg::PROD_W-1:0]       rsp_data;
  logic                                  rsp_err;
  logic                                  busy;
  logic                                  mul_start;
  logic [mult_arb_pkg::OP_W-1:0]         mul_in1;
  logic [mult_arb_pkg::OP_W-1:0]         mul_in2;
  logic [mult_arb_pkg::PROD_W-1:0]       mul_out;
  logic                                  mul_done;

  modport slave (
    input  req, a_flat, b_flat, mul_out, mul_done,
    output gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_in1, mul_in2
  );

  modport master (
    output req, a_flat, b_flat, mul_out, mul_done,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_in1, mul_in2
  );

endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping past NUM_REQ-1.
module mult_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // Scan from the farthest offset down so the nearest set bit is the last to write idx.
  always_comb begin
    valid   = |req;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (req[pos_idx]) idx = pos_idx;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one 8x8 multiplier among NUM_REQ requesters with round-robin grant.
// Optional WAIT-state timeout is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  mult_arbiter_if.slave  bus
);

  // state | meaning
  // IDLE  | no job; pick a requester and capture its operands
  // ISSUE | pulse mul_start for one cycle
  // WAIT  | operands held while the multiplier runs
  // RESP  | one-cycle rsp_valid to the granted requester

  localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]   in1_q, in1_d;
  logic [OP_W-1:0]   in2_q, in2_d;
  logic [PROD_W-1:0] rsp_data_q, rsp_data_d;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TMR_W = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;
`endif

  mult_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    rsp_data_d = rsp_data_q;
`ifdef MULT_ARB_TIMEOUT_EN
    tmr_d      = tmr_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d    = pick_idx;
          in1_d    = bus.a_flat[OP_W*int'(pick_idx) +: OP_W];
          in2_d    = bus.b_flat[OP_W*int'(pick_idx) +: OP_W];
          rr_ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        // Terminal count at zero gives exactly TIMEOUT cycles in WAIT.
        tmr_d   = TMR_W'(TIMEOUT - 1);
        err_d   = 1'b0;
`endif
      end
      WAIT: begin
        if (bus.mul_done) begin
          rsp_data_d = bus.mul_out;
          state_d    = RESP;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (tmr_q == '0) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = RESP;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign bus.rsp_err = err_q & (state_q == RESP);
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    bus.gnt       = '0;
    bus.rsp_valid = '0;
    if (state_q != IDLE) bus.gnt[idx_q]       = 1'b1;
    if (state_q == RESP) bus.rsp_valid[idx_q] = 1'b1;
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.mul_start = (state_q == ISSUE);
  assign bus.mul_in1   = in1_q;
  assign bus.mul_in2   = in2_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier, response scoreboard, table-driven single jobs
// and hand-written contention/wrap/reset/stray-done sequences (timeout when MULT_ARB_TIMEOUT_EN).
module tb_mult_arbiter;

  typedef struct {
    logic [3:0]  req;
    int          idx;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        err;
  } exp_t;

  bit   clk = 1'b0;
  logic reset_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   rsp_seen = 0;
  int   n_start = 0;
  int   mul_cnt = 0;
  int   mul_lat = 3;
  bit   mul_en = 1'b1;
  bit   stray_done = 1'b0;
  exp_t sb[$];
  vec_t vecs[4];

  mult_arbiter_if #(.NUM_REQ(4)) m ();

  mult_arbiter #(.NUM_REQ(4), .TIMEOUT(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (m)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural multiplier: done mul_lat cycles after start, samples its operands at done.
  always @(negedge clk) begin
    if (!reset_n) begin
      mul_cnt    = 0;
      m.mul_done = 1'b0;
    end else begin
      m.mul_done = stray_done;
      if (stray_done) m.mul_out = 16'hDEAD;
      if (m.mul_start) mul_cnt = mul_lat;
      else if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0 && mul_en) begin
          m.mul_done = 1'b1;
          m.mul_out  = 16'(m.mul_in1) * 16'(m.mul_in2);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (m.mul_start === 1'b1) n_start++;
    if (m.rsp_valid !== 4'b0000) begin
      rsp_seen++;
      if (sb.size() == 0) check("rsp_unexpected", 32'(m.rsp_valid), 32'h0);
      else begin
        e = sb.pop_front();
        check("rsp_valid", 32'(m.rsp_valid), 32'(1 << e.idx));
        check("rsp_data", 32'(m.rsp_data), 32'(e.data));
        check("rsp_err", 32'(m.rsp_err), 32'(e.err));
        check("gnt_at_rsp", 32'(m.gnt), 32'(1 << e.idx));
      end
    end
  end

  task automatic wait_rsp(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (rsp_seen < target && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(rsp_seen), 32'(target));
  endtask

  task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
    m.a_flat[8*idx +: 8] = a;
    m.b_flat[8*idx +: 8] = b;
  endtask

  task automatic do_job(input vec_t v);
    int s0;
    int tgt;
    @(negedge clk); #1;
    set_ops(v.idx, v.a, v.b);
    m.req = v.req;
    sb.push_back('{v.idx, v.prod, 1'b0});
    s0  = n_start;
    tgt = rsp_seen + 1;
    @(negedge clk); #1;
    check("gnt_issue", 32'(m.gnt), 32'(v.req));
    check("start_issue", 32'(m.mul_start), 32'h1);
    wait_rsp(tgt, 50, "job_rsp_count");
    check("start_pulses", 32'(n_start - s0), 32'h1);
    m.req = 4'b0000;
  endtask

  initial begin
    int base;
    vecs[0] = '{4'b0001, 0, 8'd12,  8'd11,  16'd132};
    vecs[1] = '{4'b0100, 2, 8'd255, 8'd255, 16'd65025};
    vecs[2] = '{4'b0010, 1, 8'd17,  8'd15,  16'd255};
    vecs[3] = '{4'b1000, 3, 8'd200, 8'd2,   16'd400};

    m.req    = '0;
    m.a_flat = '0;
    m.b_flat = '0;

    #12;
    check("rst_gnt", 32'(m.gnt), 32'h0);
    check("rst_rsp_valid", 32'(m.rsp_valid), 32'h0);
    check("rst_busy", 32'(m.busy), 32'h0);
    check("rst_mul_start", 32'(m.mul_start), 32'h0);
    check("rst_mul_in", {16'h0, m.mul_in1, m.mul_in2}, 32'h0);
    check("rst_rsp_data", 32'(m.rsp_data), 32'h0);
    check("rst_rsp_err", 32'(m.rsp_err), 32'h0);
    @(negedge clk); #1;
    reset_n = 1'b1;

    // Table of single-request jobs; last one is idx 3 so the pointer wraps to 0.
    for (int i = 0; i < 4; i++) do_job(vecs[i]);

    // Contention: all four held, served 0,1,2,3.
    @(negedge clk); #1;
    set_ops(0, 8'd3, 8'd5);
    set_ops(1, 8'd7, 8'd9);
    set_ops(2, 8'd255, 8'd255);
    set_ops(3, 8'd0, 8'd200);
    m.req = 4'b1111;
    sb.push_back('{0, 16'd15, 1'b0});
    sb.push_back('{1, 16'd63, 1'b0});
    sb.push_back('{2, 16'd65025, 1'b0});
    sb.push_back('{3, 16'd0, 1'b0});
    base = rsp_seen;
    wait_rsp(base + 4, 120, "contention_rsp_count");

    // Fairness / wrap: after idx 3, req=1001 grants 0 then 3.
    m.req = 4'b1001;
    sb.push_back('{0, 16'd15, 1'b0});
    sb.push_back('{3, 16'd0, 1'b0});
    @(negedge clk); #1;
    check("gnt_idle_gap", 32'(m.gnt), 32'h0);
    @(negedge clk); #1;
    check("gnt_wrap", 32'(m.gnt), 32'b0001);
    wait_rsp(base + 5, 50, "wrap_rsp_count");
    m.req = 4'b1000;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("gnt_fair", 32'(m.gnt), 32'b1000);
    wait_rsp(base + 6, 50, "fair_rsp_count");
    m.req = 4'b0000;

    // Reset in WAIT, then the still-held req is served afresh.
    mul_lat = 8;
    @(negedge clk); #1;
    set_ops(1, 8'd6, 8'd7);
    m.req = 4'b0010;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("busy_in_wait", 32'(m.busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(m.gnt), 32'h0);
    check("mid_rst_busy", 32'(m.busy), 32'h0);
    check("mid_rst_mul_in", {16'h0, m.mul_in1, m.mul_in2}, 32'h0);
    check("mid_rst_rsp_data", 32'(m.rsp_data), 32'h0);
    base = rsp_seen;
    repeat (2) @(negedge clk);
    #1;
    check("no_rsp_in_reset", 32'(rsp_seen), 32'(base));
    reset_n = 1'b1;
    sb.push_back('{1, 16'd42, 1'b0});
    wait_rsp(base + 1, 50, "post_rst_rsp_count");
    m.req   = 4'b0000;
    mul_lat = 3;

    // Stray done while idle.
    @(negedge clk); #1;
    @(negedge clk); #1;
    base = rsp_seen;
    stray_done = 1'b1;
    @(negedge clk); #1;
    stray_done = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("stray_busy", 32'(m.busy), 32'h0);
    end
    check("stray_no_rsp", 32'(rsp_seen), 32'(base));

`ifdef MULT_ARB_TIMEOUT_EN
    begin
      int n;
      mul_en = 1'b0;
      @(negedge clk); #1;
      set_ops(2, 8'd9, 8'd9);
      m.req = 4'b0100;
      sb.push_back('{2, 16'd0, 1'b1});
      base = rsp_seen;
      n = 0;
      while (m.mul_start !== 1'b1 && n < 10) begin
        @(negedge clk); #1;
        n++;
      end
      check("tmo_start_seen", 32'(m.mul_start), 32'h1);
      n = 0;
      while (rsp_seen == base && n < 100) begin
        @(negedge clk); #1;
        n++;
      end
      // First negedge after ISSUE is WAIT entry (n=1); RESP lands 32 cycles later.
      check("tmo_cycles", 32'(n), 32'd33);
      m.req  = 4'b0000;
      mul_en = 1'b1;
    end
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
